// File: rtl/relm_code_loader_if.sv
// relm_code_loader_if: host push/pop channels of the relm opcode loader
interface relm_code_loader_if #(parameter int WD = 32);
   logic [WD:0] push_d;
   logic        push_retry;
   logic [WD:0] pop_d;
   logic [WD:0] pop_q;
   modport master (output push_d, pop_d, input push_retry, pop_q);
   modport slave (input push_d, pop_d, output push_retry, pop_q);
endinterface

// File: rtl/relm_code_loader.sv
// relm_code_loader: run-time opcode memory loader for a relm core
// Optional RELM_LOADER_CHECKSUM_EN adds a running opcode sum readable through pop_d[0].
module relm_code_loader #(
   parameter int WID = 2,
   parameter int WAD = 10,
   parameter int WD  = 32,
   parameter int WOP = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   relm_code_loader_if.slave    host,
   output logic                 op_we_out,
   output logic [WAD+WID-1:0]   op_wa_out,
   output logic [WOP-1:0]       op_d_out,
   output logic                 hold_out
);
   localparam int WA    = WAD + WID;
   localparam int NPACK = (WD - 1) / WOP;
   localparam int WC    = $clog2(NPACK + 1);
   typedef enum logic [1:0] {IDLE, ARMED, WRITE, DRAINED} state_t;
   state_t state, nxt;
   logic [WA-1:0]  addr, rem, start, len, k;
   logic [WD-1:0]  word, status;
   logic [WC-1:0]  cnt;
   logic [WOP-1:0] op;
   logic           err, acc, cmd, fin, set, dat, load, wr, unused;
`ifdef RELM_LOADER_CHECKSUM_EN
   logic [WD-1:0]  sum;
`endif
   assign host.push_retry = state == WRITE;
   assign acc   = host.push_d[WD] & ~host.push_retry;
   assign cmd   = host.push_d[WD-1];
   assign fin   = host.push_d[WD-2];
   assign set   = acc & cmd & ~fin;
   assign dat   = acc & ~cmd;
   assign load  = dat & (state == ARMED);
   assign start = host.push_d[0+:WA];
   assign len   = host.push_d[WA+:WA];
   assign k     = rem < WA'(NPACK) ? rem : WA'(NPACK);
   // first opcode leaves straight from the push word so writes start at t+1
   assign wr    = load | (state == WRITE && cnt != '0);
   assign op    = load ? host.push_d[WOP-1:0] : word[WOP-1:0];
   assign unused = ^host.pop_d[WD-1:0];
   always_comb begin
      nxt = state;
      if (acc & cmd) nxt = fin ? IDLE : (len != '0 ? ARMED : DRAINED);
      else if (load) nxt = WRITE;
      else if (state == WRITE && cnt == '0) nxt = rem != '0 ? ARMED : DRAINED;
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= nxt;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         addr      <= '0;
         rem       <= '0;
         err       <= 1'b0;
         word      <= '0;
         cnt       <= '0;
         op_we_out <= 1'b0;
         op_wa_out <= '0;
         op_d_out  <= '0;
         hold_out  <= 1'b0;
      end else begin
         op_we_out <= wr;
         op_wa_out <= wr ? addr : op_wa_out;
         op_d_out  <= wr ? op : '0;
         hold_out  <= nxt != IDLE;
         if (set) begin
            addr <= start;
            rem  <= len;
         end else if (wr) begin
            addr <= addr + 1'b1;
            rem  <= rem - 1'b1;
         end
         if (set) err <= 1'b0;
         else if (acc & cmd) err <= err | (rem != '0);
         else if (dat & ~load) err <= 1'b1;
         if (load) begin
            word <= host.push_d[WD-1:0] >> WOP;
            cnt  <= WC'(k - 1'b1);
         end else if (wr) begin
            word <= word >> WOP;
            cnt  <= cnt - 1'b1;
         end
      end
   end
`ifdef RELM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst) sum <= '0;
      else sum <= set ? '0 : (wr ? sum + WD'(op) : sum);
   end
`endif
   always_comb begin
      status = '0;
      status[WD-1]  = hold_out;
      status[WD-2]  = err;
      status[WA+:WA] = rem;
      status[0+:WA]  = addr;
      host.pop_q = '0;
`ifdef RELM_LOADER_CHECKSUM_EN
      if (host.pop_d[WD]) host.pop_q[WD-1:0] = host.pop_d[0] ? sum : status;
`else
      if (host.pop_d[WD]) host.pop_q[WD-1:0] = status;
`endif
   end
endmodule
